// File: rtl/spi_master_64_if.sv
// rtl/spi_master_64_if.sv - host handshake and SPI pin bundle for spi_master_64
//
// Host side : start, wdata (to master); rdata, busy, done (from master).
// SPI side  : sclk, cs_n, mosi (from master); miso (to master).
// Optional  : loopback (to master), present only when SPI_LOOPBACK_EN is defined.
// Modports  : master (the spi_master_64 side), slave (host/peripheral side).

interface spi_master_64_if;
    logic        start;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        busy;
    logic        done;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
`ifdef SPI_LOOPBACK_EN
    logic        loopback;
`endif

    modport master (
`ifdef SPI_LOOPBACK_EN
        input  loopback,
`endif
        input  start, wdata, miso,
        output rdata, busy, done, sclk, cs_n, mosi
    );

    modport slave (
`ifdef SPI_LOOPBACK_EN
        output loopback,
`endif
        output start, wdata, miso,
        input  rdata, busy, done, sclk, cs_n, mosi
    );
endinterface

// File: rtl/spi_master_64.sv
// rtl/spi_master_64.sv - SPI mode-0 initiator for 64-bit full-duplex transfers
//
// Ports : clk (system clock, posedge), rst (synchronous, active-low),
//         bus (spi_master_64_if.master: start/wdata/rdata/busy/done, sclk/cs_n/mosi/miso).
// Params: CLK_DIV (clk cycles per sclk half-period), CS_SETUP, CS_HOLD, CS_GAP.
// Macro : SPI_LOOPBACK_EN adds bus.loopback; when set at start, rx takes the
//         registered mosi instead of miso for the whole transfer.

module spi_master_64 #(
    parameter int CLK_DIV  = 5,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 20
) (
    input  logic             clk,
    input  logic             rst,
    spi_master_64_if.master  bus
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [15:0] DIV_TC   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_TC = 16'(CS_SETUP);
    localparam logic [15:0] HOLD_TC  = 16'(CS_HOLD - 1);
    localparam logic [15:0] GAP_TC   = 16'(CS_GAP - 1);

    state_t      state, state_nx;
    logic [15:0] cnt;
    logic [15:0] div_cnt;
    logic [6:0]  bit_cnt;
    logic [62:0] tx_sr;     // bits still to send; the current bit already sits in mosi
    logic [63:0] rx_sr;
    logic [63:0] rdata_q;
    logic        sclk_q, cs_n_q, mosi_q, busy_q, done_q;
    logic        div_tc, rise, fall, rx_in;

`ifdef SPI_LOOPBACK_EN
    logic loop_q;
    assign rx_in = loop_q ? mosi_q : bus.miso;
`else
    assign rx_in = bus.miso;
`endif

    assign div_tc = (state == SHIFT) && (div_cnt == DIV_TC);
    assign rise   = div_tc && !sclk_q;
    assign fall   = div_tc &&  sclk_q;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start)                   state_nx = SETUP;
            SETUP:   if (cnt == SETUP_TC)             state_nx = SHIFT;
            SHIFT:   if (fall && bit_cnt == 7'd64)    state_nx = HOLD;
            HOLD:    if (cnt == HOLD_TC)              state_nx = GAP;
            GAP:     if (cnt == GAP_TC)               state_nx = IDLE;
            default:                                  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rdata_q <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPI_LOOPBACK_EN
            loop_q  <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            // Phase counter restarts whenever the state changes.
            cnt    <= (state_nx != state) ? 16'd0 : cnt + 16'd1;
            busy_q <= (state_nx != IDLE);
            done_q <= (state == HOLD) && (state_nx == GAP);
            // cs_n drops one cycle after accept and rises together with done.
            cs_n_q <= !(((state == SETUP) || (state == SHIFT) || (state == HOLD))
                        && (state_nx != GAP));
            if ((state == HOLD) && (state_nx == GAP))
                rdata_q <= rx_sr;

            case (state)
                IDLE: begin
                    sclk_q <= 1'b0;
                    if (bus.start) begin
                        tx_sr   <= bus.wdata[62:0];
                        mosi_q  <= bus.wdata[63];
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        rx_sr   <= '0;
`ifdef SPI_LOOPBACK_EN
                        loop_q  <= bus.loopback;
`endif
                    end else begin
                        mosi_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (div_tc) begin
                        div_cnt <= '0;
                        sclk_q  <= !sclk_q;
                        if (rise) begin
                            rx_sr   <= {rx_sr[62:0], rx_in};
                            bit_cnt <= bit_cnt + 7'd1;
                        end else if (bit_cnt < 7'd64) begin
                            mosi_q  <= tx_sr[62];
                            tx_sr   <= {tx_sr[61:0], 1'b0};
                        end else begin
                            mosi_q  <= 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                default: sclk_q <= 1'b0;
            endcase
        end
    end

    assign bus.sclk  = sclk_q;
    assign bus.cs_n  = cs_n_q;
    assign bus.mosi  = mosi_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_spi_master_64.sv
// tb/tb_spi_master_64.sv - directed self-checking bench for spi_master_64

module tb_spi_master_64;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_master_64_if bus();

    spi_master_64 #(.CLK_DIV(5), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor and slave model, sampled on negedge.
    int          pcyc = 0;
    int          rise_cnt = 0, fall_cnt = 0, cs_low = 0, done_cnt = 0, viol = 0;
    int          last_rise = 0, rise_period = 0, done_p = 0;
    logic [63:0] mon_mosi = '0;
    logic        p_sclk = 1'b0, p_cs = 1'b1, p_mosi = 1'b0;
    logic [63:0] slv_pat = '0;
    int          slv_base = 0;
    logic        slv_tie1 = 1'b0;

    always @(posedge clk) pcyc++;

    always @(negedge clk) begin
        int idx;
        if (bus.sclk && !p_sclk) begin
            mon_mosi    = {mon_mosi[62:0], bus.mosi};
            rise_cnt++;
            rise_period = pcyc - last_rise;
            last_rise   = pcyc;
        end
        if (!bus.sclk && p_sclk) fall_cnt++;
        if (!bus.cs_n) cs_low++;
        if (bus.done) begin
            done_cnt++;
            done_p = pcyc;
        end
        if (p_sclk && bus.sclk && (bus.cs_n != p_cs || bus.mosi != p_mosi)) viol++;
        idx = fall_cnt - slv_base;
        if (slv_tie1)                  bus.miso = 1'b1;
        else if (idx >= 0 && idx < 64) bus.miso = slv_pat[63 - idx];
        else                           bus.miso = 1'b0;
        p_sclk = bus.sclk;
        p_cs   = bus.cs_n;
        p_mosi = bus.mosi;
    end

    task automatic run_xfer(input logic [63:0] data, input logic [63:0] pat, input logic tie1,
                            output int acc);
        int k = 0;
        while (bus.busy && k < 1000) begin @(negedge clk); k++; end
        check("idle_before_start", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        slv_pat   = pat;
        slv_tie1  = tie1;
        slv_base  = fall_cnt;
        bus.wdata = data;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        acc = pcyc;
        check("busy_after_accept", {63'd0, bus.busy}, 64'd1);
    endtask

    task automatic wait_done(input int base);
        int k = 0;
        while (done_cnt == base && k < 2000) begin @(negedge clk); k++; end
        check("done_timeout", {63'd0, (done_cnt == base)}, 64'd0);
    endtask

    task automatic wait_rises(input int base, input int n);
        int k = 0;
        while (rise_cnt - base < n && k < 2000) begin @(negedge clk); k++; end
        check("rise_timeout", {63'd0, (rise_cnt - base < n)}, 64'd0);
    endtask

    initial begin
        int acc, rb, cb, db, k;
        bus.start = 1'b0;
        bus.wdata = '0;
`ifdef SPI_LOOPBACK_EN
        bus.loopback = 1'b0;
`endif
        // Reset held three clocks.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sclk",  {63'd0, bus.sclk}, 64'd0);
        check("rst_cs_n",  {63'd0, bus.cs_n}, 64'd1);
        check("rst_mosi",  {63'd0, bus.mosi}, 64'd0);
        check("rst_busy",  {63'd0, bus.busy}, 64'd0);
        check("rst_done",  {63'd0, bus.done}, 64'd0);
        check("rst_rdata", bus.rdata, 64'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Write: miso held low.
        rb = rise_cnt; cb = cs_low; db = done_cnt;
        run_xfer(64'hFEDCBA9876543210, 64'd0, 1'b0, acc);
        wait_done(db);
        check("wr_mosi_stream", mon_mosi, 64'hFEDCBA9876543210);
        check("wr_rises",       64'(rise_cnt - rb), 64'd64);
        check("wr_sclk_period", 64'(rise_period), 64'd10);
        check("wr_cs_low",      64'(cs_low - cb), 64'd644);
        check("wr_latency",     64'(done_p - acc), 64'd645);
        check("wr_rdata",       bus.rdata, 64'd0);

        // Read: slave shifts a pattern out on sclk falls.
        db = done_cnt;
        run_xfer(64'h0, 64'h21C9195F0A478337, 1'b0, acc);
        wait_done(db);
        check("rd_rdata", bus.rdata, 64'h21C9195F0A478337);
        check("rd_latency", 64'(done_p - acc), 64'd645);
        k = 0;
        while (bus.busy && k < 100) begin @(negedge clk); k++; end
        check("rd_busy_drop", 64'(pcyc - done_p), 64'd20);

        // Reset while idle clears rdata.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_rst_rdata", bus.rdata, 64'd0);
        check("idle_rst_cs_n",  {63'd0, bus.cs_n}, 64'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Busy rejection: second start at bit 10 is ignored.
        rb = rise_cnt; db = done_cnt; cb = cs_low;
        run_xfer(64'hFEDCBA9876543210, 64'd0, 1'b0, acc);
        wait_rises(rb, 10);
        bus.wdata = 64'h0123456789ABCDEF;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(db);
        check("rej_mosi_stream", mon_mosi, 64'hFEDCBA9876543210);
        repeat (800) @(negedge clk);
        check("rej_done_count", 64'(done_cnt - db), 64'd1);
        check("rej_rises",      64'(rise_cnt - rb), 64'd64);
        check("rej_cs_low",     64'(cs_low - cb), 64'd644);

        // Reset mid-transfer after 20 rises.
        rb = rise_cnt; db = done_cnt;
        run_xfer(64'h123456789ABCDEF0, 64'hFFFFFFFFFFFFFFFF, 1'b0, acc);
        wait_rises(rb, 20);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_cs_n",  {63'd0, bus.cs_n}, 64'd1);
        check("mid_rst_sclk",  {63'd0, bus.sclk}, 64'd0);
        check("mid_rst_mosi",  {63'd0, bus.mosi}, 64'd0);
        check("mid_rst_busy",  {63'd0, bus.busy}, 64'd0);
        check("mid_rst_rdata", bus.rdata, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (800) @(negedge clk);
        check("mid_rst_no_done", 64'(done_cnt - db), 64'd0);

        db = done_cnt;
        run_xfer(64'hAAAAAAAA55555555, 64'h3C3C00FFC3C3FF00, 1'b0, acc);
        wait_done(db);
        check("post_rst_mosi",    mon_mosi, 64'hAAAAAAAA55555555);
        check("post_rst_rdata",   bus.rdata, 64'h3C3C00FFC3C3FF00);
        check("post_rst_latency", 64'(done_p - acc), 64'd645);

`ifdef SPI_LOOPBACK_EN
        bus.loopback = 1'b1;
        db = done_cnt;
        run_xfer(64'hA5A5A5A5DEADBEEF, 64'd0, 1'b1, acc);
        bus.loopback = 1'b0;
        wait_done(db);
        check("loop_rdata", bus.rdata, 64'hA5A5A5A5DEADBEEF);
        slv_tie1 = 1'b0;
`endif

        check("protocol_violations", 64'(viol), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
